// File: rtl/instr_fetch.sv
// Instruction fetch/decode sequencer: latches an instruction, decodes its fields and
// advances the PC (sequential, jump, or resolved branch). Optional macro: HALT_ON_NOP_EN.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] imem_data,
  input  logic        br_valid,
  input  logic        br_taken,
  output logic [15:0] pc_out,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [15:0] imm,
  output logic        fetch_ready,
  output logic        halted
);

  localparam logic [5:0] OP_J   = 6'b000001;
  localparam logic [5:0] OP_BNE = 6'b100001;
  localparam logic [5:0] OP_BLT = 6'b100010;
  localparam logic [5:0] OP_BLE = 6'b100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT_BR,
    S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [31:0] ir_q;
  logic        is_jump, is_branch, halt_nop;
  logic [15:0] pc_inc, pc_tgt;

  assign opcode = ir_q[31:26];
  assign rd     = ir_q[25:21];
  assign rs     = ir_q[20:16];
  assign rt     = ir_q[15:11];
  assign imm    = ir_q[15:0];
  assign ir     = ir_q;
  assign pc_out = pc;

  assign is_jump   = (opcode == OP_J);
  assign is_branch = (opcode == OP_BNE) || (opcode == OP_BLT) || (opcode == OP_BLE);
  // 16-bit adds wrap naturally; imm as two's complement needs no sign extension here.
  assign pc_inc    = pc + 16'd1;
  assign pc_tgt    = pc_inc + imm;

`ifdef HALT_ON_NOP_EN
  assign halt_nop = (ir_q == 32'h0000_0000);
`else
  assign halt_nop = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults first on every comb output so no path leaves a value unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (fetch_req) state_nxt = S_DECODE;
      S_DECODE: begin
        if (halt_nop)       state_nxt = S_HALT;
        else if (is_branch) state_nxt = S_WAIT_BR;
        else                state_nxt = S_IDLE;
      end
      S_WAIT_BR: if (br_valid) state_nxt = S_IDLE;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_ready = (state == S_IDLE);
    ir_valid    = (state == S_DECODE);
`ifdef HALT_ON_NOP_EN
    halted      = (state == S_HALT);
`else
    halted      = 1'b0;
`endif
  end

  always_comb begin
    pc_nxt = pc;
    unique case (state)
      S_DECODE:  if (!halt_nop && !is_branch) pc_nxt = is_jump ? pc_tgt : pc_inc;
      S_WAIT_BR: if (br_valid) pc_nxt = br_taken ? pc_tgt : pc_inc;
      default:   pc_nxt = pc;
    endcase
  end

  // Reset discards any pending PC update: the next PC is only committed on a clean edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= RESET_PC;
      ir_q <= 32'h0000_0000;
    end else begin
      pc <= pc_nxt;
      if (state == S_IDLE && fetch_req) ir_q <= imem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_instr_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef HALT_ON_NOP_EN
  localparam bit HALT_NOP = 1'b1;
`else
  localparam bit HALT_NOP = 1'b0;
`endif

  logic        clk, rst, fetch_req, br_valid, br_taken;
  logic [31:0] imem_data;
  logic [15:0] pc_out, imm;
  logic [31:0] ir;
  logic        ir_valid, fetch_ready, halted;
  logic [5:0]  opcode;
  logic [4:0]  rd, rs, rt;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .imem_data(imem_data),
    .br_valid(br_valid), .br_taken(br_taken), .pc_out(pc_out), .ir(ir),
    .ir_valid(ir_valid), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .fetch_ready(fetch_ready), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the sequencer is doing, the PC, and the held instruction.
  typedef enum {M_IDLE, M_DEC, M_WAIT, M_HALT} mphase_t;
  mphase_t     m_ph;
  logic [15:0] m_pc;
  logic [31:0] m_ir;

  function automatic bit m_is_branch(input logic [31:0] w);
    return w[31:26] inside {6'b100001, 6'b100010, 6'b100011};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = M_IDLE;
      m_pc = RESET_PC;
      m_ir = 32'h0;
    end else begin
      case (m_ph)
        M_IDLE: if (fetch_req) begin
          m_ir = imem_data;
          m_ph = M_DEC;
        end
        M_DEC: begin
          if (HALT_NOP && m_ir == 32'h0) m_ph = M_HALT;
          else if (m_is_branch(m_ir)) m_ph = M_WAIT;
          else begin
            m_pc = m_pc + 16'd1 + ((m_ir[31:26] == 6'b000001) ? m_ir[15:0] : 16'd0);
            m_ph = M_IDLE;
          end
        end
        M_WAIT: if (br_valid) begin
          m_pc = m_pc + 16'd1 + (br_taken ? m_ir[15:0] : 16'd0);
          m_ph = M_IDLE;
        end
        default: m_ph = M_HALT;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_out", pc_out, m_pc);
      check("ir", ir, m_ir);
      check("ir_valid", ir_valid, m_ph == M_DEC);
      check("fetch_ready", fetch_ready, m_ph == M_IDLE);
      check("halted", halted, m_ph == M_HALT);
      check("opcode", opcode, m_ir[31:26]);
      check("rd", rd, m_ir[25:21]);
      check("rs", rs, m_ir[20:16]);
      check("rt", rt, m_ir[15:11]);
      check("imm", imm, m_ir[15:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present instr in IDLE and take one fetch edge; leaves the DUT in DECODE.
  task automatic fetch(input logic [31:0] instr);
    imem_data = instr;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
  endtask

  // Steer the PC to target with a jump whose offset is computed from the model PC.
  task automatic goto(input logic [15:0] target);
    logic [15:0] off;
    if (m_pc != target) begin
      off = target - m_pc - 16'd1;
      fetch({6'b000001, 10'd0, off});
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; fetch_req = 1'b0; br_valid = 1'b0; br_taken = 1'b0; imem_data = 32'h0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #2;
    check("rst_pc", pc_out, RESET_PC);
    check("rst_ir", ir, 32'h0);
    check("rst_ready", fetch_ready, 1'b1);
    check("rst_irv", ir_valid, 1'b0);
    check("rst_halt", halted, 1'b0);
    tick();
    rst = 1'b0;

    // Straight-line LI stream with fetch_req held high.
    imem_data = 32'hE400FFFF;
    fetch_req = 1'b1;
    check("li_pc0", pc_out, 16'd0);
    tick();
    check("li_irv", ir_valid, 1'b1);
    check("li_op", opcode, 6'b111001);
    check("li_rd", rd, 5'd0);
    tick();
    check("li_pc1", pc_out, 16'd1);
    check("li_irv_off", ir_valid, 1'b0);
    tick();
    tick();
    check("li_pc2", pc_out, 16'd2);
    fetch_req = 1'b0;

    // BNE taken after 3 WAIT_BR cycles, then not taken.
    goto(16'd12);
    fetch(32'h87F7FFFD);
    tick();
    check("bne_wait_ready", fetch_ready, 1'b0);
    check("bne_wait_pc", pc_out, 16'd12);
    fetch_req = 1'b1;
    tick();
    tick();
    fetch_req = 1'b0;
    br_valid = 1'b1; br_taken = 1'b1;
    tick();
    br_valid = 1'b0;
    check("bne_taken_pc", pc_out, 16'd10);
    goto(16'd12);
    fetch(32'h87F7FFFD);
    tick();
    tick();
    tick();
    br_valid = 1'b1; br_taken = 1'b0;
    tick();
    br_valid = 1'b0;
    check("bne_not_taken_pc", pc_out, 16'd13);

    // Jump: no WAIT_BR visit.
    goto(16'd18);
    fetch(32'h04000002);
    tick();
    check("j_pc", pc_out, 16'd21);
    check("j_ready", fetch_ready, 1'b1);

    // Wraparound in both directions.
    goto(16'hFFFF);
    fetch(32'hE4000000);
    tick();
    check("wrap_up_pc", pc_out, 16'h0000);
    fetch(32'h8800FFFE);
    tick();
    br_valid = 1'b1; br_taken = 1'b1;
    tick();
    br_valid = 1'b0;
    check("wrap_down_pc", pc_out, 16'hFFFF);

    // All-zero instruction.
    goto(16'd22);
    fetch(32'h0);
    tick();
`ifdef HALT_ON_NOP_EN
    check("nop_halted", halted, 1'b1);
    check("nop_pc", pc_out, 16'd22);
    fetch_req = 1'b1;
    tick(); tick(); tick();
    fetch_req = 1'b0;
    check("nop_still_halted", halted, 1'b1);
    check("nop_pc_hold", pc_out, 16'd22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`else
    check("nop_pc", pc_out, 16'd23);
    check("nop_halted", halted, 1'b0);
`endif

    // Asynchronous reset in the middle of WAIT_BR.
    goto(16'd5);
    fetch(32'h87F70003);
    tick();
    #3 rst = 1'b1;
    #1;
    check("arst_pc", pc_out, RESET_PC);
    check("arst_ir", ir, 32'h0);
    check("arst_ready", fetch_ready, 1'b1);
    tick();
    rst = 1'b0;
    br_valid = 1'b1; br_taken = 1'b1;
    tick();
    br_valid = 1'b0;
    check("arst_br_ignored_pc", pc_out, RESET_PC);
    check("arst_br_ignored_ready", fetch_ready, 1'b1);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 7);
      imem_data[25:0] = 26'($urandom);
      case (sel)
        0: imem_data[31:26] = 6'b000001;
        1: imem_data[31:26] = 6'b100001;
        2: imem_data[31:26] = 6'b100010;
        3: imem_data[31:26] = 6'b100011;
        4: imem_data = 32'h0;
        default: imem_data[31:26] = 6'($urandom);
      endcase
      fetch_req = ($urandom_range(0, 1) == 1);
      br_valid  = ($urandom_range(0, 9) < 3);
      br_taken  = ($urandom_range(0, 1) == 1);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0 || (m_ph == M_HALT && $urandom_range(0, 7) == 0))
        rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 fetch_req  input  1  controller requests next instruction; sampled only in IDLE.
REQ-005 imem_data  input  32  instruction returned combinationally by instruction memory for pc_out.
REQ-006 br_valid  input  1  branch condition resolved this cycle; sampled only in WAIT_BR.
REQ-007 br_taken  input  1  branch condition result; qualified by br_valid.
REQ-008 pc_out  output  16  current PC, driven to instruction memory address.
REQ-009 ir  output  32  latched instruction register.
REQ-010 ir_valid  output  1  high exactly while in DECODE.
REQ-011 opcode  output  6  ir[31:26].
REQ-012 rd  output  5  ir[25:21].
REQ-013 rs  output  5  ir[20:16].
REQ-014 rt  output  5  ir[15:11].
REQ-015 imm  output  16  ir[15:0].
REQ-016 fetch_ready  output  1  high exactly while in IDLE.
REQ-017 halted  output  1  high exactly while in HALT.

Function
REQ-018 States: IDLE, DECODE, WAIT_BR, HALT; state register encoding is implementation choice.
REQ-019 IDLE with fetch_req=1: ir <= imem_data, go to DECODE (one-cycle fetch latency); fetch_req=0: stay, nothing changes.
REQ-020 DECODE, opcode 6'b000001 (J): pc <= pc + 1 + imm, go IDLE.
REQ-021 DECODE, opcode 6'b100001/6'b100010/6'b100011 (BNE/BLT/BLE): pc holds, go WAIT_BR.
REQ-022 DECODE, any other opcode: pc <= pc + 1, go IDLE.
REQ-023 WAIT_BR with br_valid=1: pc <= br_taken ? pc + 1 + imm : pc + 1, go IDLE; br_valid=0: stay, pc holds.
REQ-024 All PC arithmetic is 16-bit modulo 2^16; imm treated as two's complement (0xFFFD = -3); 0xFFFF + 1 wraps to 0x0000.
REQ-025 fetch_req outside IDLE and br_valid outside WAIT_BR are ignored, not queued.
REQ-026 ir changes only on the IDLE->DECODE transition; ir and field outputs stable otherwise.
REQ-027 Field outputs are combinational slices of ir, valid regardless of ir_valid.
REQ-028 HALT (entered only per REQ-033) is absorbing; pc and ir hold until rst.

Reset
REQ-029 rst asserted, any state: immediately state=IDLE, pc_out=RESET_PC, ir=0, ir_valid=0, fetch_ready=1, halted=0.
REQ-030 rst mid-operation (DECODE or WAIT_BR) abandons the pending PC update; no partial update survives.
REQ-031 First fetch after rst deassertion reads address RESET_PC.

Configuration
REQ-032 Macro HALT_ON_NOP_EN selects end-of-program detection.
REQ-033 Defined: DECODE with ir == 32'h0000_0000 goes to HALT, pc holds at NOP address, halted=1.
REQ-034 Undefined: all-zero instruction handled per REQ-022 (pc+1, IDLE); halted tied 0, HALT unreachable.

Verification
REQ-035 rst, RESET_PC=0, fetch_req held 1, imem_data=32'hE400FFFF (LI) -> pc_out 0,1,2 on successive IDLE visits; each fetch gives ir_valid for one cycle, opcode=6'b111001, rd=0.
REQ-036 pc=12, imem_data=32'h87F7FFFD (BNE), br_valid=1 br_taken=1 after 3 cycles in WAIT_BR -> pc_out=10; repeat with br_taken=0 -> pc_out=13.
REQ-037 pc=18, imem_data=32'h04000002 (J) -> pc_out=21 on leaving DECODE, no WAIT_BR visit.
REQ-038 pc=16'hFFFF, non-branch instruction -> pc_out=16'h0000; pc=0, BLT imm=0xFFFE taken -> pc_out=16'hFFFF.
REQ-039 rst asserted asynchronously mid-WAIT_BR (between clock edges) -> pc_out=RESET_PC, ir=0, fetch_ready=1 before next edge; br_valid pulse afterwards has no effect.
REQ-040 imem_data=0 at pc=22: with HALT_ON_NOP_EN -> halted=1, pc_out stays 22, fetch_req ignored; without -> pc_out=23, halted=0.
